// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 2-FF synchroniser, 3-tap majority sampling, false-start rejection.
// Latency: valid_rx rises 1 clk after the last stop-bit decision (mid-stop + 1 sample).
// Backpressure: valid/ready; a frame completing while the word is still held is dropped and sets sticky overrun.
// Optional: define UART_RX_BREAK_DETECT_EN to add break_det and suppress delivery of all-zero (break) frames.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_rx,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 break_det
`endif
);

  // Bit timing. The three majority taps sit around the bit centre.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_S2   = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Synchroniser and edge-detect history
  logic                 sync1_q;
  logic                 rxs_q;
  logic                 rxs_prev_q;

  // Receive state
  state_t               state_q;
  logic [CW-1:0]        baud_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 samp0_q;
  logic                 samp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 stop_err_q;

  // Idle qualification: the line must be seen high for a full bit before a start is trusted
  logic [CW-1:0]        idle_cnt_q;
  logic                 armed_q;

  // Output register and handshake state
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_out_q;
  logic                 serr_out_q;
  logic                 overrun_q;
  logic                 busy_q;

  // Derived per-cycle decisions
  logic                 sample_maj;
  logic                 at_decide;
  logic                 start_edge;
  logic                 frame_done;
  logic                 stop_err_fin;
  logic                 par_calc;
  logic                 accept;
  logic                 deliver;
  logic                 is_break;

`ifdef UART_RX_BREAK_DETECT_EN
  logic                 all_zero_q;
  logic                 all_zero_fin;
  logic                 break_q;
`endif

  assign sample_maj   = (samp0_q & samp1_q) | (samp0_q & rxs_q) | (samp1_q & rxs_q);
  assign at_decide    = (baud_cnt_q == CNT_S2);
  assign start_edge   = rxs_prev_q & ~rxs_q;
  assign frame_done   = (state_q == ST_STOP) && at_decide && (bit_cnt_q == STOP_LAST);
  assign stop_err_fin = stop_err_q | ~sample_maj;
  assign par_calc     = ^{shift_q, sample_maj};
  assign accept       = valid_q & ready;

`ifdef UART_RX_BREAK_DETECT_EN
  // A break is a frame whose every sampled bit (data, parity, stop) was 0
  assign all_zero_fin = all_zero_q & ~sample_maj;
  assign is_break     = frame_done & all_zero_fin;
  assign break_det    = break_q;
`else
  assign is_break     = 1'b0;
`endif

  assign deliver      = frame_done & ~is_break;

  assign data_out     = data_q;
  assign valid_rx     = valid_q;
  assign parity_error = perr_out_q;
  assign stop_error   = serr_out_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

  // Bring rxd into the clk domain; reset to the idle level so no edge is seen out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receive FSM, line arming, output register and valid/ready/overrun handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      serr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      all_zero_q <= 1'b0;
      break_q    <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DETECT_EN
      break_q <= is_break;
`endif

      // Consumer takes the held word; a completing frame below may override this
      if (accept) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      // New word lands if the register is free or being emptied this cycle; otherwise it is lost
      if (deliver) begin
        if (!valid_q || ready) begin
          data_q     <= shift_q;
          perr_out_q <= par_err_q;
          serr_out_q <= stop_err_fin;
          valid_q    <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end

      // Arming: count consecutive high cycles until one full bit time has elapsed
      if (is_break) begin
        armed_q    <= 1'b0;
        idle_cnt_q <= '0;
      end else if (!armed_q) begin
        if (rxs_q) begin
          if (idle_cnt_q == CNT_LAST) begin
            armed_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + CNT_ONE;
          end
        end else begin
          idle_cnt_q <= '0;
        end
      end

      // Baud counter free-runs within a frame, wrapping once per bit
      if (state_q != ST_IDLE) begin
        baud_cnt_q <= (baud_cnt_q == CNT_LAST) ? '0 : baud_cnt_q + CNT_ONE;
      end

      // The two early majority taps
      if (baud_cnt_q == CNT_S0) begin
        samp0_q <= rxs_q;
      end
      if (baud_cnt_q == CNT_S1) begin
        samp1_q <= rxs_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (armed_q && start_edge) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        ST_START: begin
          if (at_decide) begin
            if (sample_maj) begin
              // Glitch shorter than half a bit: not a real start
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= ST_DATA;
              bit_cnt_q  <= '0;
              par_err_q  <= 1'b0;
              stop_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
              all_zero_q <= 1'b1;
`endif
            end
          end
        end

        ST_DATA: begin
          if (at_decide) begin
            shift_q <= {sample_maj, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_q <= all_zero_q & ~sample_maj;
`endif
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY == 0) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
        end

        ST_PARITY: begin
          if (at_decide) begin
            // Even: any odd count of ones over data+parity is an error; odd is the inverse
            par_err_q <= (PARITY == 2) ? ~par_calc : par_calc;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_q <= all_zero_q & ~sample_maj;
`endif
            bit_cnt_q <= '0;
            state_q   <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (at_decide) begin
            stop_err_q <= stop_err_fin;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero_q <= all_zero_fin;
`endif
            if (bit_cnt_q == STOP_LAST) begin
              // Leave at mid-stop so the next start edge is caught even with no gap
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
